// File: rtl/aes_stream_pkg.sv
// Shared types and widths for the AES stream adapter.
package aes_stream_pkg;

  localparam int BEAT_W             = 64;
  localparam int BLOCK_W            = 128;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_START,
    ST_WAIT,
    ST_OUT_LO,
    ST_OUT_HI
  } state_e;

endpackage

// File: rtl/aes_stream_adapter.sv
// Collects two 64-bit beats into one AES block and starts the core.
// Waits for the core's result and returns it as two 64-bit beats.
// Handles one block at a time. Flags framing errors and core timeouts.
module aes_stream_adapter
  import aes_stream_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BEAT_W-1:0]  s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  input  logic               s_tuser,
  input  logic [BLOCK_W-1:0] key_i,
  output logic               aes_start_o,
  output logic               aes_decrypt_o,
  output logic [BLOCK_W-1:0] aes_data_o,
  output logic [BLOCK_W-1:0] aes_key_o,
  input  logic [BLOCK_W-1:0] aes_data_i,
  input  logic               aes_ready_i,
  output logic [BEAT_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               proto_err_o,
  output logic               timeout_o,
  output logic               busy_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [BLOCK_W-1:0]   result;
  logic                 s_hs, m_hs;
  logic                 cap_lo, cap_hi, cap_res;
  logic                 cnt_clr, cnt_inc;
  logic                 proto_err_next, timeout_next, s_tready_next;

  assign s_hs = s_tvalid & s_tready;
  assign m_hs = m_tvalid & m_tready;

  // State register.
  // NOTE: every clocked assignment is non-blocking so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would otherwise infer a latch.
    state_next     = state;
    cap_lo         = 1'b0;
    cap_hi         = 1'b0;
    cap_res        = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    proto_err_next = 1'b0;
    timeout_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_hs) begin
          if (s_tlast) begin
            proto_err_next = 1'b1;           // lone last beat: drop it
          end else begin
            cap_lo     = 1'b1;
            state_next = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (s_hs) begin
          cap_hi         = 1'b1;
          proto_err_next = ~s_tlast;         // flagged, block still runs
          state_next     = ST_START;
        end
      end
      ST_START: begin
        cnt_clr    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (aes_ready_i) begin
          cap_res    = 1'b1;
          state_next = ST_OUT_LO;
        end else if (cnt == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_OUT_LO: if (m_hs) state_next = ST_OUT_HI;
      ST_OUT_HI: if (m_hs) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Input ready is registered so it stays low through reset and rises one edge later.
  assign s_tready_next = (state_next == ST_IDLE) || (state_next == ST_LO);

  // Block/key/result capture, timeout counter and registered status pulses.
  // NOTE: the latched block, key and result are reset as well. They drive
  // ports that must read zero during reset, so they are not plain storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_data_o    <= '0;
      aes_key_o     <= '0;
      aes_decrypt_o <= 1'b0;
      result        <= '0;
      cnt           <= '0;
      s_tready      <= 1'b0;
      proto_err_o   <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      s_tready    <= s_tready_next;
      proto_err_o <= proto_err_next;
      timeout_o   <= timeout_next;
      if (cap_lo) begin
        aes_data_o[BEAT_W-1:0] <= s_tdata;
        aes_key_o              <= key_i;
        aes_decrypt_o          <= s_tuser;
      end
      if (cap_hi)  aes_data_o[BLOCK_W-1:BEAT_W] <= s_tdata;
      if (cap_res) result <= aes_data_i;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;   // stops at CNT_LAST, never wraps
    end
  end

  // Output decode from the state and the held result.
  assign aes_start_o = (state == ST_START);
  assign busy_o      = (state != ST_IDLE);
  assign m_tvalid    = (state == ST_OUT_LO) || (state == ST_OUT_HI);
  assign m_tlast     = (state == ST_OUT_HI);
  assign m_tdata     = m_tlast ? result[BLOCK_W-1:BEAT_W] : result[BEAT_W-1:0];

endmodule
